// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle control FSM and the G30 datapath.
// master : the controller (consumes IR fields and status, drives controls)
// slave  : the datapath/memory side
//   opcode/funct3/funct7 : instruction register fields
//   zero                 : ALU zero flag
//   mem_ready            : memory completes the current access this cycle
//   mem_read/mem_write   : memory request strobes
//   ir_write/pc_write    : IR and PC update enables, pc_src selects PC source
//   reg_write/result_src : register file write enable and writeback mux
//   alu_src_a/alu_src_b  : ALU operand muxes, alu_control the ALU op code
//   illegal/instret      : sticky unsupported-instruction flag, retire count
interface multicycle_control_if;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        zero;
    logic        mem_ready;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic        reg_write;
    logic [1:0]  result_src;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_control;
    logic        illegal;
    logic [31:0] instret;

    modport master (
        input  opcode, funct3, funct7, zero, mem_ready,
        output mem_read, mem_write, ir_write, pc_write, pc_src, reg_write,
               result_src, alu_src_a, alu_src_b, alu_control, illegal, instret
    );

    modport slave (
        output opcode, funct3, funct7, zero, mem_ready,
        input  mem_read, mem_write, ir_write, pc_write, pc_src, reg_write,
               result_src, alu_src_a, alu_src_b, alu_control, illegal, instret
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the G30 datapath: sequences each instruction
// through fetch, decode, execute, memory and writeback, drives the ALU
// operand selects and op code, and counts retired instructions.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   ctl   : controller end of the control bundle (see multicycle_control_if)
// Outputs are decoded from the state register; pc_write in BRANCH and the
// ir_write/pc_write pair in FETCH additionally depend on zero / mem_ready.
module multicycle_control (
    input logic                 clk,
    input logic                 rst_n,
    multicycle_control_if.master ctl
);

    localparam int unsigned CNT_W = 32;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR,
        S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_ALU_WB, S_BRANCH, S_HALT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   instret_q;
    logic               retire;
    logic               r_ok;
    logic [3:0]         r_ctrl;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // R-type funct decode; unsupported combinations report r_ok=0 and op 0
    always_comb begin
        r_ok   = 1'b1;
        r_ctrl = ALU_ADD;
        case ({ctl.funct3, ctl.funct7})
            {3'b000, 7'b0000000}: r_ctrl = ALU_ADD;
            {3'b000, 7'b0100000}: r_ctrl = ALU_SUB;
            {3'b100, 7'b0000000}: r_ctrl = ALU_XOR;
            {3'b101, 7'b0000000}: r_ctrl = ALU_SRL;
            default: begin
                r_ok   = 1'b0;
                r_ctrl = 4'b0000;
            end
        endcase
    end

    // Next-state and control decode
    always_comb begin
        state_d         = state_q;
        ctl.mem_read    = 1'b0;
        ctl.mem_write   = 1'b0;
        ctl.ir_write    = 1'b0;
        ctl.pc_write    = 1'b0;
        ctl.pc_src      = 1'b0;
        ctl.reg_write   = 1'b0;
        ctl.result_src  = 2'b00;
        ctl.alu_src_a   = 2'b00;
        ctl.alu_src_b   = 2'b00;
        ctl.alu_control = 4'b0000;
        ctl.illegal     = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                ctl.mem_read    = 1'b1;
                ctl.alu_src_b   = 2'b10;
                ctl.alu_control = ALU_ADD;
                // IR and PC+4 commit only on the cycle the fetch completes
                ctl.ir_write    = ctl.mem_ready;
                ctl.pc_write    = ctl.mem_ready;
                if (ctl.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target (oldPC + imm) is parked in ALUOut here
                ctl.alu_src_a   = 2'b01;
                ctl.alu_src_b   = 2'b01;
                ctl.alu_control = ALU_ADD;
                case (ctl.opcode)
                    OPC_R:                state_d = S_EXEC_R;
                    OPC_I:                state_d = S_EXEC_I;
                    OPC_LOAD, OPC_STORE:  state_d = S_MEM_ADDR;
                    OPC_BRANCH:           state_d = S_BRANCH;
                    default:              state_d = S_HALT;
                endcase
            end
            S_EXEC_R: begin
                ctl.alu_src_a   = 2'b10;
                ctl.alu_control = r_ctrl;
                state_d         = r_ok ? S_ALU_WB : S_HALT;
            end
            S_EXEC_I: begin
                ctl.alu_src_a   = 2'b10;
                ctl.alu_src_b   = 2'b01;
                ctl.alu_control = ALU_ADD;
                state_d         = (ctl.funct3 == 3'b000) ? S_ALU_WB : S_HALT;
            end
            S_ALU_WB: begin
                ctl.reg_write = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEM_ADDR: begin
                ctl.alu_src_a   = 2'b10;
                ctl.alu_src_b   = 2'b01;
                ctl.alu_control = ALU_ADD;
                if (ctl.funct3 != 3'b010)       state_d = S_HALT;
                else if (ctl.opcode == OPC_LOAD) state_d = S_MEM_READ;
                else                             state_d = S_MEM_WRITE;
            end
            S_MEM_READ: begin
                ctl.mem_read = 1'b1;
                if (ctl.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.result_src = 2'b01;
                state_d        = S_FETCH;
            end
            S_MEM_WRITE: begin
                ctl.mem_write = 1'b1;
                if (ctl.mem_ready) state_d = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alu_src_a   = 2'b10;
                ctl.alu_control = ALU_SUB;
                ctl.pc_src      = 1'b1;
                // Only beq is supported; anything else must not touch the PC
                if (ctl.funct3 == 3'b000) begin
                    ctl.pc_write = ctl.zero;
                    state_d      = S_FETCH;
                end else begin
                    state_d      = S_HALT;
                end
            end
            S_HALT: ctl.illegal = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    // An instruction retires when its last state hands back to FETCH
    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_ALU_WB) || (state_q == S_MEM_WB) ||
                     (state_q == S_MEM_WRITE) || (state_q == S_BRANCH));

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      instret_q <= '0;
        else if (retire) instret_q <= instret_q + CNT_W'(1);
    end

    assign ctl.instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_control_if bus();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (bus)
    );

    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;
    localparam logic [3:0] XOR = 4'b0100;
    localparam logic [3:0] SRL = 4'b0101;

    typedef enum int {K_R, K_RBAD, K_I, K_IBAD, K_LW, K_SW, K_MBAD, K_BEQ, K_BBAD, K_DBAD} kind_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic  rdy;
        logic  zero;
        outs_t exp;
    } step_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        kind_t      k;
        logic [3:0] ctrl;
        int         fw;
        int         mw;
        logic       z;
    } vec_t;

    step_t       q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] ret_cnt;

    function automatic outs_t sample();
        outs_t o;
        o.mem_read    = bus.mem_read;
        o.mem_write   = bus.mem_write;
        o.ir_write    = bus.ir_write;
        o.pc_write    = bus.pc_write;
        o.pc_src      = bus.pc_src;
        o.reg_write   = bus.reg_write;
        o.result_src  = bus.result_src;
        o.alu_src_a   = bus.alu_src_a;
        o.alu_src_b   = bus.alu_src_b;
        o.alu_control = bus.alu_control;
        o.illegal     = bus.illegal;
        return o;
    endfunction

    function automatic outs_t mk(input logic [1:0] a, input logic [1:0] b, input logic [3:0] c);
        outs_t o = '0;
        o.alu_src_a   = a;
        o.alu_src_b   = b;
        o.alu_control = c;
        return o;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk_o(input string nm, input outs_t exp);
        outs_t act = sample();
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s outputs got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input logic [31:0] exp);
        total++;
        if (bus.instret !== exp) begin
            bad++;
            $display("FAIL %s instret got=%h want=%h", nm, bus.instret, exp);
        end
    endtask

    task automatic push(input logic rdy, input logic z, input outs_t o);
        step_t s;
        s.rdy = rdy; s.zero = z; s.exp = o;
        q.push_back(s);
    endtask

    // Expected cycle-by-cycle trace of one instruction, from its class
    task automatic build(input kind_t k, input logic [3:0] ctrl, input int fw, input int mw,
                         input logic z, output logic retires);
        outs_t o;
        q.delete();
        for (int i = 0; i < fw; i++) begin
            o = mk(2'b00, 2'b10, ADD); o.mem_read = 1'b1;
            push(1'b0, rbit(), o);
        end
        o = mk(2'b00, 2'b10, ADD); o.mem_read = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
        push(1'b1, rbit(), o);
        push(rbit(), rbit(), mk(2'b01, 2'b01, ADD));
        retires = 1'b1;
        case (k)
            K_R:    push(rbit(), rbit(), mk(2'b10, 2'b00, ctrl));
            K_RBAD: push(rbit(), rbit(), mk(2'b10, 2'b00, 4'b0000));
            K_I, K_IBAD, K_LW, K_SW, K_MBAD: push(rbit(), rbit(), mk(2'b10, 2'b01, ADD));
            K_BEQ: begin
                o = mk(2'b10, 2'b00, SUB); o.pc_src = 1'b1; o.pc_write = z;
                push(rbit(), z, o);
            end
            K_BBAD: begin
                o = mk(2'b10, 2'b00, SUB); o.pc_src = 1'b1;
                push(rbit(), z, o);
            end
            default: ;
        endcase
        case (k)
            K_R, K_I: begin
                o = '0; o.reg_write = 1'b1; push(rbit(), rbit(), o);
            end
            K_LW: begin
                o = '0; o.mem_read = 1'b1;
                for (int i = 0; i < mw; i++) push(1'b0, rbit(), o);
                push(1'b1, rbit(), o);
                o = '0; o.reg_write = 1'b1; o.result_src = 2'b01; push(rbit(), rbit(), o);
            end
            K_SW: begin
                o = '0; o.mem_write = 1'b1;
                for (int i = 0; i < mw; i++) push(1'b0, rbit(), o);
                push(1'b1, rbit(), o);
            end
            K_BEQ: ;
            default: begin
                retires = 1'b0;
                o = '0; o.illegal = 1'b1;
                push(rbit(), rbit(), o);
                push(rbit(), rbit(), o);
            end
        endcase
    endtask

    // IR fields are changed only once the previous instruction is back in FETCH
    task automatic run(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input int stop_at);
        for (int i = 0; i < q.size() && i < stop_at; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus.opcode = op; bus.funct3 = f3; bus.funct7 = f7;
            end
            bus.mem_ready = q[i].rdy;
            bus.zero      = q[i].zero;
            #1;
            chk_o($sformatf("%s.c%0d", tag, i), q[i].exp);
            chk_i($sformatf("%s.c%0d", tag, i), ret_cnt);
        end
    endtask

    task automatic reset_dut(input string tag);
        rst_n = 1'b0;
        #1;
        chk_o({tag, ".rst"}, '0);
        chk_i({tag, ".rst"}, 32'd0);
        ret_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_o({tag, ".idle"}, '0);
    endtask

    task automatic do_instr(input string tag, input vec_t v);
        logic r;
        build(v.k, v.ctrl, v.fw, v.mw, v.z, r);
        run(tag, v.op, v.f3, v.f7, 1000);
        if (r) ret_cnt = ret_cnt + 32'd1;
        else   reset_dut({tag, ".after_halt"});
    endtask

    // Reference decode of an instruction into its class
    function automatic void classify(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                     output kind_t k, output logic [3:0] ctrl);
        ctrl = ADD;
        if (op == 7'b0110011) begin
            k = K_R;
            if      (f3 == 3'd0 && f7 == 7'd0)         ctrl = ADD;
            else if (f3 == 3'd0 && f7 == 7'b0100000)   ctrl = SUB;
            else if (f3 == 3'd4 && f7 == 7'd0)         ctrl = XOR;
            else if (f3 == 3'd5 && f7 == 7'd0)         ctrl = SRL;
            else                                       k = K_RBAD;
        end else if (op == 7'b0010011) k = (f3 == 3'd0) ? K_I : K_IBAD;
        else if (op == 7'b0000011)     k = (f3 == 3'd2) ? K_LW : K_MBAD;
        else if (op == 7'b0100011)     k = (f3 == 3'd2) ? K_SW : K_MBAD;
        else if (op == 7'b1100011)     k = (f3 == 3'd0) ? K_BEQ : K_BBAD;
        else                           k = K_DBAD;
    endfunction

    initial begin
        vec_t tbl[15];
        vec_t v;
        logic [6:0] ops[6];
        logic [2:0] r3[3];
        logic r;

        tbl[0]  = '{7'b0110011, 3'b000, 7'b0000000, K_R,    ADD, 0, 0, 1'b0};
        tbl[1]  = '{7'b0110011, 3'b000, 7'b0100000, K_R,    SUB, 0, 0, 1'b0};
        tbl[2]  = '{7'b0110011, 3'b100, 7'b0000000, K_R,    XOR, 0, 0, 1'b0};
        tbl[3]  = '{7'b0110011, 3'b101, 7'b0000000, K_R,    SRL, 0, 0, 1'b0};
        tbl[4]  = '{7'b0010011, 3'b000, 7'b1010101, K_I,    ADD, 1, 0, 1'b0};
        tbl[5]  = '{7'b0000011, 3'b010, 7'b0000000, K_LW,   ADD, 0, 3, 1'b0};
        tbl[6]  = '{7'b0100011, 3'b010, 7'b0000000, K_SW,   ADD, 0, 2, 1'b0};
        tbl[7]  = '{7'b1100011, 3'b000, 7'b0000000, K_BEQ,  ADD, 0, 0, 1'b1};
        tbl[8]  = '{7'b1100011, 3'b000, 7'b0000000, K_BEQ,  ADD, 0, 0, 1'b0};
        tbl[9]  = '{7'b0110011, 3'b000, 7'b0000000, K_R,    ADD, 5, 0, 1'b0};
        tbl[10] = '{7'b0110011, 3'b100, 7'b0100000, K_RBAD, ADD, 0, 0, 1'b0};
        tbl[11] = '{7'b1111111, 3'b000, 7'b0000000, K_DBAD, ADD, 0, 0, 1'b0};
        tbl[12] = '{7'b0000011, 3'b000, 7'b0000000, K_MBAD, ADD, 0, 0, 1'b0};
        tbl[13] = '{7'b1100011, 3'b001, 7'b0000000, K_BBAD, ADD, 0, 0, 1'b1};
        tbl[14] = '{7'b0010011, 3'b001, 7'b0000000, K_IBAD, ADD, 0, 0, 1'b0};

        rst_n = 1'b0;
        bus.opcode = '0; bus.funct3 = '0; bus.funct7 = '0;
        bus.zero = 1'b0; bus.mem_ready = 1'b0;
        ret_cnt = '0;
        @(negedge clk);
        reset_dut("init");

        // Directed vectors
        foreach (tbl[i]) do_instr($sformatf("vec%0d", i), tbl[i]);

        // Reset while a store is waiting on memory
        do_instr("pre_sw0", tbl[0]);
        do_instr("pre_sw1", tbl[4]);
        build(K_SW, ADD, 0, 3, 1'b0, r);
        run("sw_abort", 7'b0100011, 3'b010, 7'b0, 4);
        #2;
        reset_dut("sw_abort");

        // Counter wrap: preload all-ones while idle, then retire one
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        ret_cnt = 32'hFFFF_FFFF;
        do_instr("wrap_a", tbl[4]);
        do_instr("wrap_b", tbl[7]);

        // Randomized instruction stream
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
        ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b1111111;
        r3[0] = 3'b000; r3[1] = 3'b100; r3[2] = 3'b101;
        for (int n = 0; n < 60; n++) begin
            v.op = ops[$urandom_range(0, 5)];
            if (v.op == 7'b1111111) v.op = 7'($urandom());
            if ($urandom_range(0, 9) < 8) begin
                case (v.op)
                    7'b0110011: v.f3 = r3[$urandom_range(0, 2)];
                    7'b0000011, 7'b0100011: v.f3 = 3'b010;
                    default: v.f3 = 3'b000;
                endcase
                v.f7 = (v.f3 == 3'b000 && rbit()) ? 7'b0100000 : 7'b0000000;
            end else begin
                v.f3 = 3'($urandom());
                v.f7 = 7'($urandom());
            end
            v.fw = $urandom_range(0, 2);
            v.mw = $urandom_range(0, 2);
            v.z  = rbit();
            classify(v.op, v.f3, v.f7, v.k, v.ctrl);
            do_instr($sformatf("rnd%0d", n), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM for the G30 datapath. It is the driving end of the ALU interface.
- Decodes the instruction register fields and sequences each instruction through fetch, decode, execute, memory and writeback.
- Each cycle it selects the ALU operands and drives the 4-bit ALU operation code.
- Consumes the ALU `zero` flag to resolve beq, and handshakes with instruction/data memory via `mem_ready`.

Parameters:
- ALU_ADD, 4'b0010, ALU code for add
- ALU_SUB, 4'b0110, ALU code for sub
- ALU_XOR, 4'b0100, ALU code for xor
- ALU_SRL, 4'b0101, ALU code for srl

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_read  out  1  memory read request (fetch or load)
- mem_write  out  1  memory write request (store)
- ir_write  out  1  latch fetched word into IR
- pc_write  out  1  update PC
- pc_src  out  1  0: PC <= ALU result; 1: PC <= ALUOut register
- reg_write  out  1  register file write enable
- result_src  out  2  00 ALUOut, 01 memory data, others reserved (driven 00)
- alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1
- alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
- alu_control  out  4  ALU operation code
- illegal  out  1  sticky unsupported-instruction flag
- instret  out  32  retired-instruction counter

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, ALU_WB, BRANCH, HALT.
- Outputs are Moore (decoded from the state register), except two Mealy terms: pc_write in BRANCH, and the handshake-gated enables in FETCH.

Reset:
- rst_n low sets state to IDLE immediately.
- All outputs read 0 and instret reads 0. illegal clears.
- Reset mid-instruction abandons it; no write enable stays asserted.

IDLE:
- All outputs 0. Goes to FETCH after one cycle.

FETCH:
- mem_read=1, alu_src_a=00, alu_src_b=10, alu_control=ADD, pc_src=0.
- ir_write and pc_write equal mem_ready.
- Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.

DECODE:
- alu_src_a=01, alu_src_b=01, ADD (branch target into ALUOut).
- Dispatch on opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - any other opcode -> HALT

EXEC_R:
- alu_src_a=10, alu_src_b=00. alu_control from funct3/funct7:
  - 000/0000000 ADD
  - 000/0100000 SUB
  - 100/0000000 XOR
  - 101/0000000 SRL
- Any other funct combination -> HALT, not ALU_WB.
- Otherwise -> ALU_WB.

EXEC_I:
- addi only (funct3=000): alu_src_a=10, alu_src_b=01, ADD -> ALU_WB.
- Other funct3 -> HALT.

ALU_WB:
- reg_write=1, result_src=00 -> FETCH.

MEM_ADDR:
- alu_src_a=10, alu_src_b=01, ADD.
- funct3 must be 010 (lw/sw), else HALT.
- Load -> MEM_READ; store -> MEM_WRITE.

MEM_READ:
- mem_read=1, held until mem_ready; then -> MEM_WB.

MEM_WB:
- reg_write=1, result_src=01 -> FETCH.

MEM_WRITE:
- mem_write=1, held until mem_ready; then -> FETCH.

BRANCH (beq only, funct3=000, else HALT):
- alu_src_a=10, alu_src_b=00, SUB, pc_src=1.
- pc_write = zero, combinational in that cycle.
- -> FETCH.

HALT:
- illegal=1, all enables 0. Stays in HALT until reset.

Handshake:
- mem_read and mem_write never both high.
- A request stays stable until the edge where mem_ready=1.
- mem_ready outside FETCH/MEM_READ/MEM_WRITE is ignored.

instret:
- Increments by 1 on each transition into FETCH from ALU_WB, MEM_WB, MEM_WRITE or BRANCH.
- Wraps 0xFFFFFFFF -> 0. Never increments from IDLE.

Unspecified select fields:
- In states where a select field is don't-care it is driven 0, so the bench can check exact values.

Test Plan:
- Reset then add (opcode 0110011, f3 000, f7 0000000), mem_ready=1 every cycle -> states IDLE, FETCH, DECODE, EXEC_R (alu_control=0010), ALU_WB (reg_write=1); instret=1 on the fifth edge.
- sub/xor/srl variants -> EXEC_R alu_control 0110/0100/0101 respectively; f7=0100000 with f3=100 -> HALT, illegal=1 sticky, instret unchanged.
- lw with mem_ready low for 3 cycles in MEM_READ -> mem_read held 4 cycles, no reg_write until MEM_WB, result_src=01 there; sw -> mem_write held until mem_ready, no reg_write.
- beq with zero=1 -> BRANCH pc_write=1, pc_src=1, alu_control=0110; with zero=0 -> pc_write=0; both return to FETCH and increment instret.
- FETCH stall: mem_ready=0 for 5 cycles -> ir_write=pc_write=0 throughout, asserted only on the ready cycle.
- rst_n pulsed low during MEM_WRITE -> mem_write drops to 0 asynchronously, instret=0, illegal=0; restart from IDLE. Preload instret=0xFFFFFFFF via retirements/force -> wraps to 0.
